// File: rtl/binary_tower_pkg.sv
`default_nettype none
// ============================================================================
// Module  : binary_tower_pkg
// Brief   : Shared constants, FSM encoding and width helper for the binary
//           tower-field multiply-by-alpha^n engine.
// Revision: 1.0 - initial release
// ============================================================================
package binary_tower_pkg;

  // Deepest tower level supported by the datapath (W = 128 bits).
  localparam int TOWER_MAX_LEVEL = 7;
  // Largest number of chained mul_alpha steps per ITER cycle.
  localparam int UNROLL_MAX = 4;

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Element width of a level-L tower field element.
  function automatic int tower_width(input int level);
    return 1 << level;
  endfunction

endpackage
`default_nettype wire

// File: rtl/binary_tower_mul_alpha_step.sv
`default_nettype none
// ============================================================================
// Module  : binary_tower_mul_alpha_step
// Brief   : One combinational mul_alpha step on a single level-LEVEL element:
//           mul_alpha_L({a1,a0}) = {a0 ^ mul_alpha_(L-1)(a1), a1},
//           mul_alpha_0(x) = x. Pure XOR and wiring.
// Revision: 1.0 - initial release
// ============================================================================
module binary_tower_mul_alpha_step #(
  parameter int LEVEL = 5
) (
  input  logic [(1 << LEVEL)-1:0] a,
  output logic [(1 << LEVEL)-1:0] y
);

  localparam int W = 1 << LEVEL;

  // The recursion always descends into the upper half, so level j operates on
  // the top 2^j bits of a. Each level's result is packed into a flat vector at
  // offset 2^j-1 (width 2^j), building bottom-up from level 0.
  logic [2*W-2:0] w_m;

  assign w_m[0] = a[W-1];

  generate
    for (genvar j = 1; j <= LEVEL; j++) begin : g_level
      localparam int H = 1 << (j - 1);
      // hi half of the level-j slice is a[W-1 -: H], lo half a[W-1-H -: H]
      assign w_m[(2*H-1) +: 2*H] = {a[W-1-H -: H] ^ w_m[(H-1) +: H], a[W-1 -: H]};
    end
  endgenerate

  assign y = w_m[(W-1) +: W];

endmodule
`default_nettype wire

// File: rtl/binary_tower_mul_alpha_pow.sv
`default_nettype none
// ============================================================================
// Module  : binary_tower_mul_alpha_pow
// Brief   : Multi-lane multiply-by-alpha^n engine. Each accepted beat carries
//           LANES tower elements and one exponent; the exponent is consumed
//           UNROLL mul_alpha steps per cycle. valid/ready on both sides.
// Revision: 1.0 - initial release
// ============================================================================
module binary_tower_mul_alpha_pow
  import binary_tower_pkg::*;
#(
  parameter int LEVEL  = 5,
  parameter int LANES  = 4,
  parameter int EXP_W  = 8,
  parameter int UNROLL = 1
) (
  input  logic                                   ap_clk,
  input  logic                                   ap_rst_n,
  input  logic                                   ap_ce,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [LANES*tower_width(LEVEL)-1:0]    in_data,
  input  logic [EXP_W-1:0]                       in_exp,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [LANES*tower_width(LEVEL)-1:0]    out_data,
  output logic                                   busy
);

  localparam int W  = tower_width(LEVEL);
  localparam int DW = LANES * W;
  localparam logic [EXP_W-1:0] C_UNROLL = EXP_W'(UNROLL);

  logic [1:0]       r_state;
  logic [DW-1:0]    r_acc;
  logic [EXP_W-1:0] r_cnt;

  logic [DW-1:0]    w_chain [0:UNROLL];
  logic [EXP_W-1:0] w_k;
  logic             w_accept;

  // Step chain: stage u applies one more step only while the remaining count
  // exceeds u, so the last ITER cycle applies exactly min(UNROLL, cnt) steps.
  assign w_chain[0] = r_acc;

  generate
    for (genvar u = 0; u < UNROLL; u++) begin : g_stage
      logic [DW-1:0] w_stepped;
      for (genvar l = 0; l < LANES; l++) begin : g_lane
        binary_tower_mul_alpha_step #(
          .LEVEL (LEVEL)
        ) u_step (
          .a (w_chain[u][l*W +: W]),
          .y (w_stepped[l*W +: W])
        );
      end
      assign w_chain[u+1] = (r_cnt > EXP_W'(u)) ? w_stepped : w_chain[u];
    end
  endgenerate

  assign w_k = (r_cnt < C_UNROLL) ? r_cnt : C_UNROLL;

  // Handshake decode. ap_ce acts as a global stall shared with the neighbours,
  // so the flags are not gated by it; the state simply does not advance.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign out_data  = r_acc;
  assign busy      = (r_state != ST_IDLE);

  // FSM with accumulator and remaining-step counter; a retire in DONE may load
  // the next beat on the same edge so back-to-back beats see no bubble.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (ap_ce) begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_acc   <= in_data;
            r_cnt   <= in_exp;
            r_state <= (in_exp != '0) ? ST_ITER : ST_DONE;
          end else if ((r_state == ST_DONE) && out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        ST_ITER: begin
          r_acc <= w_chain[UNROLL];
          r_cnt <= r_cnt - w_k;
          if (r_cnt <= C_UNROLL) begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
